fp12_result_unloader: RTL and testbench

- Downstream stage of the pairing core top level. It unloads a finished Fp12 result (12 words) from core RAM after execution completes.
- Waits for is_busy to fall, then issues REF_RESULT read address pairs (two words per cycle).
- Captures outdata1/outdata2 after the RAM read latency and serialises them onto a one-word valid/ready stream toward the host interface.

---
 rtl/fp12_result_unloader.sv | 212 +++++++++++++++++++++
 tb/tb_fp12_result_unloader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp12_result_unloader.sv
// ---------------------------------------------------------------------------
// fp12_result_unloader
//
// Unloads a finished Fp12 result (NWORDS words) from the pairing core RAM.
// After a start request it waits for the core to go idle, then takes over
// the core mode/address inputs and reads the result two words per cycle
// (REF_RESULT mode). The returned data goes into a small 4-word FIFO, and
// the FIFO drives a one-word valid/ready stream toward the host.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle unload request (only honoured in IDLE)
//   base_addr        first RAM address of the result
//   core_busy        core is_busy; the unload waits for it to drop
//   core_outdata1/2  core read-port data, valid RD_LAT cycles after raddr
//   mode_req, mode   ownership of the core mode input (MODE_REF while owned)
//   raddr1, raddr2   read addresses for the even/odd word of each pair
//   o_data, o_valid, o_ready, o_last   output word stream
//   busy             unload in progress (not IDLE)
//   done             one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module fp12_result_unloader #(
    parameter int                WORD_W   = 384,
    parameter int                ADDR_W   = 10,
    parameter int                MODE_W   = 3,
    parameter logic [MODE_W-1:0] MODE_REF = 3'd4,
    parameter int                NWORDS   = 12,
    parameter int                RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              core_busy,
    input  logic [WORD_W-1:0] core_outdata1,
    input  logic [WORD_W-1:0] core_outdata2,
    output logic              mode_req,
    output logic [MODE_W-1:0] mode,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              busy,
    output logic              done
);

    localparam int NPAIRS = NWORDS / 2;
    localparam int PC_W   = $clog2(NPAIRS + 1);
    localparam int WC_W   = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   raddr1_q, raddr2_q;
    logic [PC_W-1:0]     pcnt_q;
    logic [WC_W-1:0]     wcnt_q;
    logic                mode_req_q, busy_q, done_q;
    logic [MODE_W-1:0]   mode_q;

    // vld_pipe_q[0] marks a pair whose address is on raddr this cycle;
    // vld_pipe_q[RD_LAT] marks the cycle its data is on core_outdata.
    logic [RD_LAT:0]     vld_pipe_q;

    // 4-word FIFO, written two words at a time, read one word at a time.
    logic [WORD_W-1:0]   fifo_q [4];
    logic [1:0]          wptr_q, rptr_q;
    logic [2:0]          cnt_q, cnt_d;

    logic [7:0]          inflight;
    logic [7:0]          occ_need;
    logic                credit_ok;
    logic                issue;
    logic                push;
    logic                pop;
    logic                last_pop;
    logic [ADDR_W-1:0]   pair_off;

    // Worst-case occupancy if another pair is issued now: current words,
    // plus two per pair still travelling through the RAM, plus the new pair.
    always_comb begin
        inflight = 8'd0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + 8'(vld_pipe_q[i]);
        end
        occ_need  = 8'(cnt_q) + (inflight << 1) + 8'd2;
        credit_ok = (occ_need <= 8'd4);
    end

    assign issue    = (state_q == S_READ) && credit_ok;
    assign push     = vld_pipe_q[RD_LAT];
    assign pop      = (cnt_q != 3'd0) && o_ready;
    assign last_pop = pop && (wcnt_q == WC_W'(NWORDS - 1));
    assign pair_off = ADDR_W'(pcnt_q) << 1;

    always_comb begin
        cnt_d = cnt_q;
        if (push) cnt_d = cnt_d + 3'd2;
        if (pop)  cnt_d = cnt_d - 3'd1;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            pcnt_q     <= '0;
            wcnt_q     <= '0;
            mode_req_q <= 1'b0;
            mode_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            done_q        <= 1'b0;
            vld_pipe_q[0] <= issue;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end

            // Accepted-word index; doubles as the o_last selector.
            if (pop) begin
                wcnt_q <= last_pop ? '0 : wcnt_q + WC_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        pcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!core_busy) begin
                        mode_req_q <= 1'b1;
                        mode_q     <= MODE_REF;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        // Address arithmetic wraps modulo 2^ADDR_W.
                        raddr1_q <= base_q + pair_off;
                        raddr2_q <= base_q + pair_off + ADDR_W'(1);
                        pcnt_q   <= pcnt_q + PC_W'(1);
                        if (pcnt_q == PC_W'(NPAIRS - 1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // All pairs are issued; the final word leaving the FIFO
                    // means the pipe and FIFO are both empty after this edge.
                    if (last_pop) begin
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        mode_req_q <= 1'b0;
                        mode_q     <= '0;
                        raddr1_q   <= '0;
                        raddr2_q   <= '0;
                        pcnt_q     <= '0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 2'd2;
            if (pop)  rptr_q <= rptr_q + 2'd1;
            cnt_q <= cnt_d;
        end
    end

    // FIFO storage; contents are only observable through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q]        <= core_outdata1;
            fifo_q[wptr_q + 2'd1] <= core_outdata2;
        end
    end

    assign mode_req = mode_req_q;
    assign mode     = mode_q;
    assign raddr1   = raddr1_q;
    assign raddr2   = raddr2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign o_valid  = (cnt_q != 3'd0);
    assign o_data   = o_valid ? fifo_q[rptr_q] : '0;
    assign o_last   = o_valid && (wcnt_q == WC_W'(NWORDS - 1));

endmodule

// File: tb/tb_fp12_result_unloader.sv
module tb_fp12_result_unloader;

    localparam int WW = 384;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          core_busy = 1'b0;
    logic [WW-1:0] core_outdata1 = '0;
    logic [WW-1:0] core_outdata2 = '0;
    logic          o_ready = 1'b1;
    logic          mode_req, o_valid, o_last, busy, done;
    logic [2:0]    mode;
    logic [AW-1:0] raddr1, raddr2;
    logic [WW-1:0] o_data;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [WW-1:0] mem [0:1023];
    logic [WW-1:0] rx_q [$];
    bit            last_q [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_cyc = 0;
    bit            stall_prev = 1'b0;
    logic [WW-1:0] prev_data = '0;

    fp12_result_unloader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .core_busy(core_busy), .core_outdata1(core_outdata1),
        .core_outdata2(core_outdata2), .mode_req(mode_req), .mode(mode),
        .raddr1(raddr1), .raddr2(raddr2), .o_data(o_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_last(o_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM model with one cycle of read latency.
    always @(posedge clk) begin
        cyc           <= cyc + 1;
        core_outdata1 <= mem[raddr1];
        core_outdata2 <= mem[raddr2];
    end

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] pat(input int a);
        logic [15:0] v;
        v = a[15:0] ^ 16'h5A00;
        return {v, 352'd0, ~v};
    endfunction

    // Stream monitor: records transfers, done pulses, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", WW'(o_valid), WW'(1));
                chk("stall_data", o_data, prev_data);
            end
            chk("occ_le4", WW'(dut.cnt_q > 3'd4), '0);
            if (o_valid && o_ready) begin
                rx_q.push_back(o_data);
                last_q.push_back(o_last);
                last_cyc = cyc;
            end
            stall_prev = o_valid && !o_ready;
            prev_data  = o_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit bp);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < maxc) begin
            @(posedge clk); #1;
            if (bp) o_ready = ((n % 4) == 0) || ((n % 4) == 3);
            n++;
        end
        o_ready = 1'b1;
        chk("done_seen", WW'(done_cnt - d0), WW'(1));
    endtask

    task automatic check_stream(input string tag, input int b);
        chk({tag, "_count"}, WW'(rx_q.size()), WW'(12));
        for (int k = 0; k < rx_q.size() && k < 12; k++) begin
            chk({tag, "_data"}, rx_q[k], mem[(b + k) % 1024]);
            chk({tag, "_last"}, WW'(last_q[k]), WW'(k == 11));
        end
        chk({tag, "_done_lat"}, WW'(done_cyc - last_cyc), WW'(1));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mode_req"}, WW'(mode_req), '0);
        chk({tag, "_mode"}, WW'(mode), '0);
        chk({tag, "_raddr1"}, WW'(raddr1), '0);
        chk({tag, "_raddr2"}, WW'(raddr2), '0);
        chk({tag, "_o_valid"}, WW'(o_valid), '0);
        chk({tag, "_o_last"}, WW'(o_last), '0);
        chk({tag, "_o_data"}, o_data, '0);
        chk({tag, "_busy"}, WW'(busy), '0);
        chk({tag, "_done"}, WW'(done), '0);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        last_q.delete();
    endtask

    task automatic wait_raddr(input logic [AW-1:0] a, input int maxc);
        int n = 0;
        while (raddr1 !== a && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("raddr_reach", WW'(raddr1), WW'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int a = 0; a < 1024; a++) mem[a] = pat(a);
        for (int i = 0; i < 12; i++) mem[16'h100 + i] = WW'(i + 16'hA0);

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle("reset");
        #1 rst = 1'b0;

        // Basic unload with exact latency checks
        clear_rx();
        d0 = done_cnt;
        pulse_start(10'h100);
        @(negedge clk);
        chk("basic_busy", WW'(busy), WW'(1));
        chk("basic_req_wait", WW'(mode_req), '0);
        @(negedge clk);
        chk("basic_req_read", WW'(mode_req), WW'(1));
        chk("basic_mode", WW'(mode), WW'(4));
        chk("basic_raddr_pre", WW'(raddr1), '0);
        @(negedge clk);
        chk("basic_raddr1", WW'(raddr1), WW'(10'h100));
        chk("basic_raddr2", WW'(raddr2), WW'(10'h101));
        chk("basic_nvalid0", WW'(o_valid), '0);
        @(negedge clk);
        chk("basic_nvalid1", WW'(o_valid), '0);
        @(negedge clk);
        chk("basic_first_valid", WW'(o_valid), WW'(1));
        chk("basic_first_data", o_data, WW'(16'hA0));
        wait_done(200, 1'b0);
        check_stream("basic", 16'h100);
        if (rx_q.size() == 12) chk("basic_word11", rx_q[11], WW'(16'hAB));
        @(negedge clk);
        chk("basic_post_req", WW'(mode_req), '0);
        chk("basic_post_busy", WW'(busy), '0);
        chk("basic_post_raddr", WW'(raddr1), '0);
        chk("basic_one_done", WW'(done_cnt - d0), WW'(1));

        // Wait for core; busy re-rising during READ is ignored
        clear_rx();
        core_busy = 1'b1;
        pulse_start(10'h200);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("wait_req", WW'(mode_req), '0);
            chk("wait_raddr", WW'(raddr1), '0);
            chk("wait_busy", WW'(busy), WW'(1));
        end
        @(posedge clk); #1;
        core_busy = 1'b0;
        @(negedge clk);
        chk("wait_req_still0", WW'(mode_req), '0);
        @(negedge clk);
        chk("wait_req_rise", WW'(mode_req), WW'(1));
        chk("wait_raddr_pre", WW'(raddr1), '0);
        @(negedge clk);
        chk("wait_first_issue", WW'(raddr1), WW'(10'h200));
        #1 core_busy = 1'b1;
        wait_done(200, 1'b0);
        core_busy = 1'b0;
        check_stream("waitcore", 16'h200);

        // Backpressure 1,0,0,1
        clear_rx();
        pulse_start(10'h080);
        wait_done(400, 1'b1);
        check_stream("bp", 16'h080);

        // Address wrap
        clear_rx();
        pulse_start(10'h3FA);
        wait_done(200, 1'b0);
        check_stream("wrap", 16'h3FA);
        if (rx_q.size() == 12) chk("wrap_word6", rx_q[6], pat(0));

        // Start during DRAIN is ignored
        clear_rx();
        d0 = done_cnt;
        pulse_start(10'h180);
        wait_raddr(10'h18A, 100);
        pulse_start(10'h000);
        wait_done(200, 1'b0);
        check_stream("ignstart", 16'h180);
        repeat (40) @(negedge clk);
        chk("ign_one_done", WW'(done_cnt - d0), WW'(1));
        chk("ign_count", WW'(rx_q.size()), WW'(12));
        chk("ign_busy", WW'(busy), '0);

        // Reset mid-READ, then a fresh unload
        clear_rx();
        pulse_start(10'h300);
        wait_raddr(10'h304, 100);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        #1 rst = 1'b0;
        clear_rx();
        d0 = done_cnt;
        pulse_start(10'h040);
        wait_done(200, 1'b0);
        check_stream("fresh", 16'h040);
        repeat (10) @(negedge clk);
        chk("fresh_one_done", WW'(done_cnt - d0), WW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
